// File: rtl/tl_pkg.sv
// Shared traffic-light encodings: phase values and monitor error codes.
// Used by tl_monitor and by the light controller it observes.
package tl_pkg;

    typedef enum logic [1:0] {
        PH_UNSYNC = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_RED    = 2'b11
    } phase_e;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_ILLEGAL = 3'd1,
        ERR_MULTI   = 3'd2,
        ERR_SHORT   = 3'd3,
        ERR_STUCK   = 3'd4
    } err_e;

    // Phase a single transition pulse leads into, whichever phase it came from.
    function automatic phase_e evt_dest(input logic gty, input logic ytr);
        if (gty)
            return PH_YELLOW;
        else if (ytr)
            return PH_RED;
        else
            return PH_GREEN;
    endfunction

endpackage

// File: rtl/tl_dwell_cnt.sv
// Saturating up-counter with synchronous clear (wins over enable).
// Holds at all-ones instead of wrapping.
module tl_dwell_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         res,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != {W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/tl_monitor.sv
// Traffic-light sequence monitor: tracks phase, counts RED->GREEN cycles, latches first error.
// Define TL_MON_TIMING_EN to add SHORT/STUCK phase-duration checks.
module tl_monitor
    import tl_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int MIN_RED    = 4,
    parameter int MAX_PHASE  = 200
) (
    input  logic             clk,
    input  logic             res,
    input  logic             gty,
    input  logic             ytr,
    input  logic             rtg,
    input  logic             clr_err,
    output logic [1:0]       phase,
    output logic             synced,
    output logic             err,
    output logic [2:0]       err_code,
    output logic [CNT_W-1:0] cycles
);

    if (MIN_GREEN < 1 || MIN_YELLOW < 1 || MIN_RED < 1 || MAX_PHASE < 1 ||
        MAX_PHASE >= (1 << CNT_W)) begin : g_bad_cfg
        $error("tl_monitor: MIN_* must be >= 1 and MAX_PHASE within 1..2^CNT_W-1");
    end

    phase_e           r_phase;
    logic             r_synced;
    logic             r_err;
    err_e             r_err_code;
    logic [CNT_W-1:0] r_cycles;

    logic [CNT_W-1:0] w_dwell;
    logic [1:0]       w_evt_cnt;
    logic             w_single;
    logic             w_multi;
    logic             w_legal;
    logic             w_illegal;
    logic             w_short;
    logic             w_stuck;
    logic             w_dwell_en;
    phase_e           w_dest;
    err_e             w_new_err;

    assign w_evt_cnt  = {1'b0, gty} + {1'b0, ytr} + {1'b0, rtg};
    assign w_single   = (w_evt_cnt == 2'd1);
    assign w_multi    = (w_evt_cnt >= 2'd2);
    assign w_dest     = evt_dest(gty, ytr);
    assign w_legal    = w_single && r_synced &&
                        ((gty && r_phase == PH_GREEN) ||
                         (ytr && r_phase == PH_YELLOW) ||
                         (rtg && r_phase == PH_RED));
    assign w_illegal  = w_single && r_synced && !w_legal;
    // A colliding (multi) cycle is not a transition, so dwell keeps running.
    assign w_dwell_en = r_synced && !w_single;

    tl_dwell_cnt #(
        .W (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .res   (res),
        .i_clr (w_single),
        .i_en  (w_dwell_en),
        .o_cnt (w_dwell)
    );

`ifdef TL_MON_TIMING_EN
    logic [31:0] w_min;

    always_comb begin
        w_min = 32'(MIN_RED);
        case (r_phase)
            PH_GREEN:  w_min = 32'(MIN_GREEN);
            PH_YELLOW: w_min = 32'(MIN_YELLOW);
            default:   w_min = 32'(MIN_RED);
        endcase
    end

    // Duration of the phase being left is dwell+1 at the event edge.
    assign w_short = w_legal && ((32'(w_dwell) + 32'd1) < w_min);
    // Fires only on the edge that moves dwell onto MAX_PHASE, hence once per phase.
    assign w_stuck = w_dwell_en && (32'(w_dwell) == 32'(MAX_PHASE - 1));
`else
    assign w_short = 1'b0;
    assign w_stuck = 1'b0;
`endif

    always_comb begin
        w_new_err = ERR_NONE;
        if (w_multi)
            w_new_err = ERR_MULTI;
        else if (w_illegal)
            w_new_err = ERR_ILLEGAL;
        else if (w_short)
            w_new_err = ERR_SHORT;
        else if (w_stuck)
            w_new_err = ERR_STUCK;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_phase    <= PH_UNSYNC;
            r_synced   <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_cycles   <= '0;
        end else begin
            if (w_single) begin
                r_phase  <= w_dest;
                r_synced <= 1'b1;
            end
            if (w_legal && rtg)
                r_cycles <= r_cycles + 1'b1;
            if (clr_err) begin
                r_err      <= (w_new_err != ERR_NONE);
                r_err_code <= w_new_err;
            end else if (!r_err && (w_new_err != ERR_NONE)) begin
                r_err      <= 1'b1;
                r_err_code <= w_new_err;
            end
        end
    end

    assign phase    = r_phase;
    assign synced   = r_synced;
    assign err      = r_err;
    assign err_code = r_err_code;
    assign cycles   = r_cycles;

endmodule

// File: tb/tb_tl_monitor.sv
// Directed bench for tl_monitor; expectations hand-derived for default parameters.
// Builds with or without TL_MON_TIMING_EN.
module tb_tl_monitor;

`ifdef TL_MON_TIMING_EN
    localparam logic TIMING = 1'b1;
`else
    localparam logic TIMING = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       res;
    logic       gty;
    logic       ytr;
    logic       rtg;
    logic       clr_err;
    logic [1:0] phase;
    logic       synced;
    logic       err;
    logic [2:0] err_code;
    logic [7:0] cycles;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tl_monitor #(
        .CNT_W      (8),
        .MIN_GREEN  (4),
        .MIN_YELLOW (2),
        .MIN_RED    (4),
        .MAX_PHASE  (200)
    ) dut (
        .clk      (clk),
        .res      (res),
        .gty      (gty),
        .ytr      (ytr),
        .rtg      (rtg),
        .clr_err  (clr_err),
        .phase    (phase),
        .synced   (synced),
        .err      (err),
        .err_code (err_code),
        .cycles   (cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_ph, input logic e_sy,
                           input logic e_er, input logic [2:0] e_cd, input logic [7:0] e_cy);
        chk({tag, ".phase"},    {30'd0, phase},    {30'd0, e_ph});
        chk({tag, ".synced"},   {31'd0, synced},   {31'd0, e_sy});
        chk({tag, ".err"},      {31'd0, err},      {31'd0, e_er});
        chk({tag, ".err_code"}, {29'd0, err_code}, {29'd0, e_cd});
        chk({tag, ".cycles"},   {24'd0, cycles},   {24'd0, e_cy});
    endtask

    // One clock with the given inputs held across the edge; returns 1 time unit after it.
    task automatic step(input logic g, input logic y, input logic r, input logic c);
        gty     = g;
        ytr     = y;
        rtg     = r;
        clr_err = c;
        @(posedge clk);
        #1;
        gty     = 1'b0;
        ytr     = 1'b0;
        rtg     = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        res = 1'b0; gty = 1'b0; ytr = 1'b0; rtg = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 2'd0, 1'b0, 1'b0, 3'd0, 8'd0);
        res = 1'b1;

        idle(2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("sync_rtg", 2'd1, 1'b1, 1'b0, 3'd0, 8'd0);

        idle(4);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("legal_gty", 2'd2, 1'b1, 1'b0, 3'd0, 8'd0);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("legal_ytr", 2'd3, 1'b1, 1'b0, 3'd0, 8'd0);
        idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("legal_rtg", 2'd1, 1'b1, 1'b0, 3'd0, 8'd1);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("illegal_ytr", 2'd3, 1'b1, 1'b1, 3'd1, 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("clr_err", 2'd3, 1'b1, 1'b0, 3'd0, 8'd1);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("resync_rtg", 2'd1, 1'b1, 1'b0, 3'd0, 8'd2);

        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("multi_green", 2'd1, 1'b1, 1'b1, 3'd2, 8'd2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("multi_clr", 2'd1, 1'b1, 1'b0, 3'd0, 8'd2);

        // GREEN dwell is 2 here (multi cycle kept counting): 2 more idles -> duration 5.
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("min_durations", 2'd1, 1'b1, 1'b0, 3'd0, 8'd3);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("short_gty", 2'd2, 1'b1, TIMING, TIMING ? 3'd3 : 3'd0, 8'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("short_clr", 2'd2, 1'b1, 1'b0, 3'd0, 8'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("enter_red", 2'd3, 1'b1, 1'b0, 3'd0, 8'd3);

        idle(199);
        chk_all("red_dwell_199", 2'd3, 1'b1, 1'b0, 3'd0, 8'd3);
        idle(1);
        chk_all("stuck", 2'd3, 1'b1, TIMING, TIMING ? 3'd4 : 3'd0, 8'd3);
        idle(10);
        chk_all("stuck_hold", 2'd3, 1'b1, TIMING, TIMING ? 3'd4 : 3'd0, 8'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("stuck_clr", 2'd3, 1'b1, 1'b0, 3'd0, 8'd3);
        idle(60);
        chk_all("stuck_once", 2'd3, 1'b1, 1'b0, 3'd0, 8'd3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("rtg_after_sat", 2'd1, 1'b1, 1'b0, 3'd0, 8'd4);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("illegal2", 2'd3, 1'b1, 1'b1, 3'd1, 8'd4);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk_all("clr_with_multi", 2'd3, 1'b1, 1'b1, 3'd2, 8'd4);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("first_latched", 2'd2, 1'b1, 1'b1, 3'd2, 8'd4);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk_all("clr2", 2'd2, 1'b1, 1'b0, 3'd0, 8'd4);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("to_red", 2'd3, 1'b1, 1'b0, 3'd0, 8'd4);

        for (int k = 0; k < 251; k++) begin
            idle(3);
            step(1'b0, 1'b0, 1'b1, 1'b0);
            idle(3);
            step(1'b1, 1'b0, 1'b0, 1'b0);
            idle(1);
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk_all("pre_wrap", 2'd3, 1'b1, 1'b0, 3'd0, 8'd255);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("wrap", 2'd1, 1'b1, 1'b0, 3'd0, 8'd0);

        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("after_wrap", 2'd1, 1'b1, 1'b0, 3'd0, 8'd1);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk_all("multi_yellow", 2'd2, 1'b1, 1'b1, 3'd2, 8'd1);

        #2;
        res = 1'b0;
        #1;
        chk_all("async_reset", 2'd0, 1'b0, 1'b0, 3'd0, 8'd0);
        @(posedge clk);
        #1;
        chk_all("reset_held", 2'd0, 1'b0, 1'b0, 3'd0, 8'd0);
        res = 1'b1;

        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("post_reset_sync", 2'd3, 1'b1, 1'b0, 3'd0, 8'd0);
        idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("post_reset_rtg", 2'd1, 1'b1, 1'b0, 3'd0, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
